// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and models multi-cycle latency.
// The result is computed at launch, held as pending, and committed when the busy counter expires.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUO
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [31:0]   hi_r, lo_r, pend_hi_r, pend_lo_r;
    logic          busy_r, pend_wr_r;
    logic [CW-1:0] cnt_r;

    logic          start_s, pend_wr_s, div_signed_s;
    logic [31:0]   pend_hi_s, pend_lo_s, mduo_s;
    logic [CW-1:0] cnt_load_s;
    logic [63:0]   sprod_s, uprod_s;
    logic [31:0]   a_mag_s, b_mag_s, b_safe_s, uquo_s, urem_s, quo_s, rem_s;

    // Launch qualification: only MDU arithmetic ops, and only when idle.
    always_comb begin
        start_s = 1'b0;
        case (MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_s = ~busy_r;
            default:                            start_s = 1'b0;
        endcase
    end

    // Arithmetic datapath; signed divide runs on magnitudes so overflow falls out naturally.
    always_comb begin
        sprod_s      = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        uprod_s      = {32'd0, A} * {32'd0, B};
        div_signed_s = (MDUOp == OP_DIV);
        a_mag_s      = (div_signed_s && A[31]) ? (32'd0 - A) : A;
        b_mag_s      = (div_signed_s && B[31]) ? (32'd0 - B) : B;
        b_safe_s     = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        uquo_s       = a_mag_s / b_safe_s;
        urem_s       = a_mag_s % b_safe_s;
        quo_s        = (div_signed_s && (A[31] ^ B[31])) ? (32'd0 - uquo_s) : uquo_s;
        rem_s        = (div_signed_s && A[31]) ? (32'd0 - urem_s) : urem_s;
    end

    // Select pending result, commit enable and latency for the presented op.
    always_comb begin
        pend_hi_s  = 32'd0;
        pend_lo_s  = 32'd0;
        pend_wr_s  = 1'b0;
        cnt_load_s = {CW{1'b0}};
        case (MDUOp)
            OP_MULT: begin
                {pend_hi_s, pend_lo_s} = sprod_s;
                pend_wr_s  = 1'b1;
                cnt_load_s = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
                {pend_hi_s, pend_lo_s} = uprod_s;
                pend_wr_s  = 1'b1;
                cnt_load_s = CW'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                pend_hi_s  = rem_s;
                pend_lo_s  = quo_s;
                pend_wr_s  = (B != 32'd0);
                cnt_load_s = CW'(DIV_CYCLES);
            end
            default: begin
                pend_wr_s  = 1'b0;
            end
        endcase
    end

    // Combinational HI/LO read port for mfhi/mflo.
    always_comb begin
        mduo_s = 32'd0;
        case (MDUOp)
            OP_MFHI: mduo_s = hi_r;
            OP_MFLO: mduo_s = lo_r;
            default: mduo_s = 32'd0;
        endcase
    end

    // Launch, countdown, commit and idle-time mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else if (start_s) begin
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            pend_wr_r <= pend_wr_s;
            cnt_r     <= cnt_load_s;
            busy_r    <= 1'b1;
        end else if (busy_r) begin
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r <= 1'b0;
                if (pend_wr_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end
            end
        end else begin
            if (MDUOp == OP_MTHI) hi_r <= A;
            if (MDUOp == OP_MTLO) lo_r <= A;
        end
    end

    assign start = start_s;
    assign busy  = busy_r;
    assign HI    = hi_r;
    assign LO    = lo_r;
    assign MDUO  = mduo_s;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, arithmetic, divide-by-zero, reset abort, back-to-back ops.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        start, busy;
    logic [31:0] HI, LO, MDUO;
    int n_vec = 0;
    int n_err = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .MDUO(MDUO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (HI !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h exp %h", HI, 32'd0); end
        n_vec++; if (LO !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h exp %h", LO, 32'd0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start got %b exp 0", start); end
        n_vec++; if (MDUO !== 32'd0) begin n_err++; $display("FAIL reset_mduo got %h exp %h", MDUO, 32'd0); end
    endtask

    // Launch op in the current cycle T, hold busy window, land in cycle T+cycles+1.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cycles, input logic [31:0] old_hi, input string name);
        MDUOp = op; A = a; B = b;
        #1;
        n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL %s_start got %b exp 1", name, start); end
        tick();
        MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        for (int k = 1; k <= cycles; k++) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy_T+%0d got %b exp 1", name, k, busy); end
            n_vec++; if (HI !== old_hi) begin n_err++; $display("FAIL %s_hold_hi_T+%0d got %h exp %h", name, k, HI, old_hi); end
            tick();
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_idle got %b exp 0", name, busy); end
    endtask

    task automatic test_mult();
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'd0, "mult");
        n_vec++; if (HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h exp %h", HI, 32'hFFFFFFFF); end
        n_vec++; if (LO !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_lo got %h exp %h", LO, 32'hFFFFFFFA); end
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, "multu");
        n_vec++; if (HI !== 32'h00000002) begin n_err++; $display("FAIL multu_hi got %h exp %h", HI, 32'h2); end
        n_vec++; if (LO !== 32'hFFFFFFFA) begin n_err++; $display("FAIL multu_lo got %h exp %h", LO, 32'hFFFFFFFA); end
    endtask

    task automatic test_div();
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000002, "div");
        n_vec++; if (LO !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo got %h exp %h", LO, 32'hFFFFFFFD); end
        n_vec++; if (HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got %h exp %h", HI, 32'hFFFFFFFF); end
        run_op(4'd4, 32'd7, 32'd2, 10, 32'hFFFFFFFF, "divu");
        n_vec++; if (LO !== 32'd3) begin n_err++; $display("FAIL divu_lo got %h exp %h", LO, 32'd3); end
        n_vec++; if (HI !== 32'd1) begin n_err++; $display("FAIL divu_hi got %h exp %h", HI, 32'd1); end
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd1, "divovf");
        n_vec++; if (LO !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo got %h exp %h", LO, 32'h80000000); end
        n_vec++; if (HI !== 32'd0) begin n_err++; $display("FAIL divovf_hi got %h exp %h", HI, 32'd0); end
    endtask

    task automatic test_div_zero();
        MDUOp = 4'd7; A = 32'h12345678;
        tick();
        MDUOp = 4'd0; A = 32'd0;
        n_vec++; if (HI !== 32'h12345678) begin n_err++; $display("FAIL mthi got %h exp %h", HI, 32'h12345678); end
        run_op(4'd3, 32'd5, 32'd0, 10, 32'h12345678, "div0");
        n_vec++; if (HI !== 32'h12345678) begin n_err++; $display("FAIL div0_hi got %h exp %h", HI, 32'h12345678); end
        n_vec++; if (LO !== 32'h80000000) begin n_err++; $display("FAIL div0_lo got %h exp %h", LO, 32'h80000000); end
        MDUOp = 4'd5; #1;
        n_vec++; if (MDUO !== 32'h12345678) begin n_err++; $display("FAIL mfhi got %h exp %h", MDUO, 32'h12345678); end
        MDUOp = 4'd6; #1;
        n_vec++; if (MDUO !== 32'h80000000) begin n_err++; $display("FAIL mflo got %h exp %h", MDUO, 32'h80000000); end
        MDUOp = 4'd8; A = 32'h0BADF00D;
        tick();
        MDUOp = 4'd0; A = 32'd0;
        n_vec++; if (LO !== 32'h0BADF00D) begin n_err++; $display("FAIL mtlo got %h exp %h", LO, 32'h0BADF00D); end
    endtask

    task automatic test_reset_mid();
        MDUOp = 4'd1; A = 32'd2; B = 32'd3;
        tick();
        MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        n_vec++; if (HI !== 32'd0) begin n_err++; $display("FAIL rstmid_hi got %h exp %h", HI, 32'd0); end
        n_vec++; if (LO !== 32'd0) begin n_err++; $display("FAIL rstmid_lo got %h exp %h", LO, 32'd0); end
        for (int k = 0; k < 8; k++) tick();
        n_vec++; if (LO !== 32'd0) begin n_err++; $display("FAIL rstmid_nocommit_lo got %h exp %h", LO, 32'd0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_late_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        MDUOp = 4'd1; A = 32'h00010000; B = 32'h00010000;
        tick();
        MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        tick();
        MDUOp = 4'd8; A = 32'hDEADBEEF;
        #1;
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL b2b_mtlo_start got %b exp 0", start); end
        tick();
        MDUOp = 4'd3; A = 32'd1; B = 32'd1;
        #1;
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL b2b_busy_start got %b exp 0", start); end
        MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick(); tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_t6_busy got %b exp 0", busy); end
        n_vec++; if (HI !== 32'd1) begin n_err++; $display("FAIL b2b_mult_hi got %h exp %h", HI, 32'd1); end
        n_vec++; if (LO !== 32'd0) begin n_err++; $display("FAIL b2b_mult_lo got %h exp %h", LO, 32'd0); end
        run_op(4'd3, 32'd100, 32'd7, 10, 32'd1, "b2b_div");
        n_vec++; if (LO !== 32'd14) begin n_err++; $display("FAIL b2b_div_lo got %h exp %h", LO, 32'd14); end
        n_vec++; if (HI !== 32'd2) begin n_err++; $display("FAIL b2b_div_hi got %h exp %h", HI, 32'd2); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
